mux_n_1_rr: RTL and testbench

MUX_N_1_RR -- requirements
Module: mux_n_1_rr

---
 rtl/mux_n_1_rr.sv | 114 +++++++++++
 tb/tb_mux_n_1_rr.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/mux_n_1_rr.sv
// N:1 multiplexer with a registered output slot, fixed or round-robin grant.
module mux_n_1_rr #(
  parameter int unsigned WIDTH    = 3,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned SW       = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      mode,
  input  logic [SW-1:0]             select,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [SW-1:0]             out_chan,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [15:0]               xfer_count
);

  localparam int unsigned CW = 16;

  logic [WIDTH-1:0] data_q, data_d;
  logic [SW-1:0]    chan_q, chan_d;
  logic             valid_q, valid_d;
  logic [SW-1:0]    ptr_q, ptr_d;
  logic [CW-1:0]    count_q, count_d;

  logic [WIDTH-1:0] ch_data [CHANNELS];
  logic [SW-1:0]    grant;
  logic [SW-1:0]    cand;
  logic             grant_vld;
  logic             load_en;
  logic             accept;

  // Unpack the flat input bus into per-channel words.
  always_comb begin
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      ch_data[i] = in_data[i*WIDTH +: WIDTH];
    end
  end

  // Grant selection: the fixed select, or the first valid channel at or after ptr.
  always_comb begin
    grant     = select;
    grant_vld = in_valid[select];
    cand      = ptr_q;
    if (mode) begin
      grant     = ptr_q;
      grant_vld = 1'b0;
      for (int unsigned k = 0; k < CHANNELS; k++) begin
        cand = ptr_q + SW'(k);
        if (!grant_vld && in_valid[cand]) begin
          grant_vld = 1'b1;
          grant     = cand;
        end
      end
    end
  end

  assign load_en = !valid_q || out_ready;
  assign accept  = reset && load_en && grant_vld;

  // One-hot accept toward the granted channel; silent while in reset.
  always_comb begin
    in_ready = '0;
    if (accept) begin
      in_ready = CHANNELS'(1) << grant;
    end
  end

  // Next state of the output slot, round-robin pointer and transfer counter.
  always_comb begin
    data_d  = data_q;
    chan_d  = chan_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    if (accept) begin
      data_d  = ch_data[grant];
      chan_d  = grant;
      valid_d = 1'b1;
      count_d = count_q + CW'(1);
      if (mode) begin
        ptr_d = grant + SW'(1);
      end
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      data_q  <= '0;
      chan_q  <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
      count_q <= '0;
    end else begin
      data_q  <= data_d;
      chan_q  <= chan_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end

  assign out_data   = data_q;
  assign out_chan   = chan_q;
  assign out_valid  = valid_q;
  assign xfer_count = count_q;

endmodule

// File: tb/tb_mux_n_1_rr.sv
// Scoreboard bench for mux_n_1_rr: model predicts grants, monitor checks outputs.
module tb_mux_n_1_rr;

  localparam int W = 3;
  localparam int C = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic           mode;
  logic [1:0]     select;
  logic [C*W-1:0] in_data;
  logic [C-1:0]   in_valid;
  logic [C-1:0]   in_ready;
  logic [W-1:0]   out_data;
  logic [1:0]     out_chan;
  logic           out_valid;
  logic           out_ready;
  logic [15:0]    xfer_count;

  mux_n_1_rr #(.WIDTH(W), .CHANNELS(C)) dut (
    .clk(clk), .reset(reset), .mode(mode), .select(select),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid),
    .out_ready(out_ready), .xfer_count(xfer_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  logic [4:0] sb [$];
  int         m_ptr   = 0;
  logic       m_valid = 1'b0;
  logic [15:0] m_count = 16'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: drive inputs after the edge, check against the reference, advance it.
  task automatic step(input logic rst, input logic m, input logic [1:0] sel,
                      input logic [3:0] v, input logic [11:0] d, input logic ordy);
    logic       load;
    logic       found;
    int         g;
    int         c;
    logic [3:0] exp_rdy;
    @(posedge clk);
    #2;
    reset = rst; mode = m; select = sel; in_valid = v; in_data = d; out_ready = ordy;
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("xfer_count", 32'(xfer_count), 32'(m_count));
    exp_rdy = 4'b0000;
    if (!rst) begin
      m_valid = 1'b0; m_ptr = 0; m_count = 16'd0;
      sb.delete();
    end else begin
      load  = !m_valid || ordy;
      found = 1'b0;
      g     = 0;
      if (!m) begin
        found = v[sel];
        g     = int'(sel);
      end else begin
        for (int k = 0; k < C; k++) begin
          c = (m_ptr + k) % C;
          if (!found && v[c]) begin found = 1'b1; g = c; end
        end
      end
      if (load && found) begin
        exp_rdy = 4'b0001 << g;
        sb.push_back({d[g*W +: W], 2'(g)});
        m_valid = 1'b1;
        m_count = m_count + 16'd1;
        if (m) m_ptr = (g + 1) % C;
      end else if (ordy) begin
        m_valid = 1'b0;
      end
    end
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
  endtask

  // Monitor: each taken output item must match the oldest predicted item.
  always @(negedge clk) begin
    if (reset === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_out", 32'(out_valid), 32'd0);
      end else begin
        chk("out_item", 32'({out_data, out_chan}), 32'(sb.pop_front()));
      end
    end
  end

  logic [2:0] held;

  initial begin
    reset = 1'b0; mode = 1'b0; select = 2'd0; in_valid = '0; in_data = '0; out_ready = 1'b0;

    // Fixed select 2 with every channel valid.
    step(0, 0, 2'd0, 4'b0000, 12'h000, 1);
    step(1, 0, 2'd2, 4'b1111, {3'b011, 3'b101, 3'b110, 3'b001}, 1);
    chk("fix_rdy", 32'(in_ready), 32'b0100);
    step(1, 0, 2'd2, 4'b0000, 12'h000, 0);
    chk("fix_data", 32'(out_data), 32'b101);
    chk("fix_chan", 32'(out_chan), 32'd2);

    // Round-robin fairness over six cycles.
    step(0, 1, 2'd0, 4'b0000, 12'h000, 1);
    for (int i = 0; i < 6; i++) step(1, 1, 2'd0, 4'b1111, 12'(i * 291), 1);
    step(1, 1, 2'd0, 4'b0000, 12'h000, 1);
    chk("rr_count6", 32'(xfer_count), 32'd6);

    // Skip idle channels: ptr=1 with channels 0 and 3 requesting.
    step(0, 1, 2'd0, 4'b0000, 12'h000, 1);
    step(1, 1, 2'd0, 4'b0001, 12'h007, 1);
    step(1, 1, 2'd0, 4'b1001, 12'hA05, 1);
    chk("skip_g3", 32'(in_ready), 32'b1000);
    step(1, 1, 2'd0, 4'b1001, 12'hA05, 1);
    chk("skip_g0", 32'(in_ready), 32'b0001);

    // Backpressure holds the output and blocks inputs.
    step(1, 1, 2'd0, 4'b1111, 12'hFFF, 0);
    held = out_data;
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 2'd0, 4'b1111, 12'(i * 1234), 0);
      chk("bp_rdy", 32'(in_ready), 32'd0);
      chk("bp_hold", 32'(out_data), 32'(held));
    end
    step(1, 1, 2'd0, 4'b1111, 12'h0C3, 1);
    step(1, 1, 2'd0, 4'b0000, 12'h000, 1);
    chk("bp_resume_valid", 32'(out_valid), 32'd1);

    // Mid-operation reset with a held item.
    step(0, 1, 2'd0, 4'b0000, 12'h000, 1);
    for (int i = 0; i < 5; i++) step(1, 1, 2'd0, 4'b0110, 12'hB6D, 1);
    step(1, 1, 2'd0, 4'b0000, 12'h000, 0);
    step(0, 1, 2'd0, 4'b1111, 12'hFFF, 1);
    step(1, 1, 2'd0, 4'b1111, 12'h5AF, 1);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_rdy_ch0", 32'(in_ready), 32'b0001);

    // Randomized traffic with occasional reset.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 63) != 0), 1'($urandom), 2'($urandom), 4'($urandom),
           12'($urandom), ($urandom_range(0, 3) != 0));
    end

    // Counter wrap.
    step(0, 1, 2'd0, 4'b0000, 12'h000, 1);
    for (int i = 0; i < 65535; i++) step(1, 1, 2'd0, 4'b1111, 12'(i), 1);
    step(1, 1, 2'd0, 4'b1111, 12'h123, 1);
    chk("wrap_ffff", 32'(xfer_count), 32'h0000FFFF);
    step(1, 1, 2'd0, 4'b0000, 12'h000, 1);
    chk("wrap_zero", 32'(xfer_count), 32'd0);
    step(1, 1, 2'd0, 4'b0000, 12'h000, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
